mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Latency: 33 cycles from the start edge to HI/LO update and o_done, for every op and operand.
// Backpressure: o_busy is high while an operation runs; i_start and HI/LO writes are ignored then.
module mult_div_unit (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data_rs,
  input  logic [31:0] i_data_rt,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;      // {partial/remainder, multiplier/quotient}
  logic [31:0] mcand_q, mcand_d;  // |B|: multiplicand or divisor
  logic        sa_q, sa_d;        // A negative and op is signed
  logic        sb_q, sb_d;        // B negative and op is signed
  logic        bz_q, bz_d;        // divisor was zero
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_trial;
  logic [63:0] div_step;
  logic [63:0] prod_fix;

  // State and datapath registers; reset clears everything and aborts any operation
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      acc_q   <= 64'd0;
      mcand_q <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state: 32 CALC cycles (counter 0..31), then one FIX cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-iteration step logic: shift-add multiply and restoring divide on magnitudes
  always_comb begin
    a_neg     = i_op[0] & i_data_rs[31];
    b_neg     = i_op[0] & i_data_rt[31];
    mag_a     = a_neg ? (32'd0 - i_data_rs) : i_data_rs;
    mag_b     = b_neg ? (32'd0 - i_data_rt) : i_data_rt;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    mul_step  = {mul_sum, acc_q[31:1]};
    div_trial = acc_q[63:31] - {1'b0, mcand_q};
    div_step  = div_trial[32] ? {acc_q[62:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
    prod_fix  = (op_q[0] & (sa_q ^ sb_q)) ? (64'd0 - acc_q) : acc_q;
  end

  // Datapath updates: operand capture, iteration, sign fix-up and MTHI/MTLO writes
  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // A start wins over simultaneous HI/LO writes
          op_d    = i_op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          bz_d    = (i_data_rt == 32'd0);
          mcand_d = mag_b;
          acc_d   = {32'd0, mag_a};
          cnt_d   = 6'd0;
        end else begin
          if (i_hi_we) hi_d = i_data_rs;
          if (i_lo_we) lo_d = i_data_rs;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = op_q[1] ? div_step : mul_step;
      end
      S_FIX: begin
        done_d = 1'b1;
        cnt_d  = 6'd0;
        if (!op_q[1]) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (bz_q) begin
          // Divide by zero: all-ones quotient, remainder is A itself
          lo_d = 32'hFFFF_FFFF;
          hi_d = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
          lo_d = (op_q[0] & (sa_q ^ sb_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
          hi_d = (op_q[0] & sa_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end
      end
      default: ;
    endcase
  end

  // Outputs: busy from state, done and HI/LO straight from registers
  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = done_q;
    o_hi   = hi_q;
    o_lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_hi_we, i_lo_we;
  logic [1:0]  i_op;
  logic [31:0] i_data_rs, i_data_rt;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int n_cmp  = 0;
  int n_fail = 0;
  logic bad_busy, bad_hold;

  localparam logic [1:0] OP_MULTU = 2'd0, OP_MULT = 2'd1, OP_DIVU = 2'd2, OP_DIV = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  mult_div_unit dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_data_rs(i_data_rs), .i_data_rt(i_data_rt),
    .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
    .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definitions
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    int          ia, ib;
    longint      sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up, uq, ur;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      OP_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      OP_MULT:  begin sp = sa * sb; up = sp; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == OP_DIVU) begin
          uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0];
        end else begin
          sq = sa / sb; sr = sa % sb; uq = sq; ur = sr; lo = uq[31:0]; hi = ur[31:0];
        end
      end
    endcase
  endtask

  // Present a start at the current negedge; returns one negedge after the start edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1; i_op = op; i_data_rs = a; i_data_rt = b;
    @(negedge clk);
    i_start = 1'b0;
    i_op = 2'($urandom_range(0, 3));
    i_data_rs = $urandom; i_data_rt = $urandom;
  endtask

  // Wait for o_done with a bound; tracks busy and HI/LO stability while running
  task automatic wait_done(input int lat0, input logic [31:0] ph, input logic [31:0] pl,
                           output int lat);
    lat = lat0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (o_done) break;
      if (!o_busy) bad_busy = 1'b1;
      if (o_hi !== ph || o_lo !== pl) bad_hold = 1'b1;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    logic [31:0] ph, pl;
    ph = o_hi; pl = o_lo;
    bad_busy = 1'b0; bad_hold = 1'b0;
    issue(op, a, b);
    wait_done(0, ph, pl, lat);
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " result"}, {o_hi, o_lo}, {eh, el});
    chk({nm, " busy/hold"}, {62'd0, bad_busy, bad_hold}, 64'd0);
    chk({nm, " busy low at done"}, {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic [1:0]  op;
    int lat, sel;
    logic saw_done;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    // Reset with start and writes asserted: reset must win
    i_reset = 1'b1; i_start = 1'b1; i_hi_we = 1'b1; i_lo_we = 1'b1;
    i_op = OP_MULTU; i_data_rs = 32'hDEAD_BEEF; i_data_rt = 32'd5;
    repeat (3) @(negedge clk);
    chk("reset state", {28'd0, o_busy, o_done, 2'd0, o_hi, o_lo}, 64'd0);
    i_reset = 1'b0; i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
    @(negedge clk);
    chk("idle after reset", {62'd0, o_busy, o_done}, 64'd0);

    // Directed vector table; each op starts in the cycle the previous done is high
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Done is a single-cycle pulse
    @(negedge clk);
    chk("done one cycle", {63'd0, o_done}, 64'd0);

    // Randomised ops against the model
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
            (sel == 2) ? 32'($urandom_range(1, 15)) : 32'($urandom);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(op, a, b, eh, el);
      run_op($sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b), op, a, b, eh, el);
    end

    // Start and HI write during busy are ignored
    @(negedge clk);
    bad_busy = 1'b0; bad_hold = 1'b0;
    issue(OP_MULTU, 32'd1000, 32'd3000);
    chk("busy after start", {63'd0, o_busy}, 64'd1);
    repeat (9) @(negedge clk);
    i_start = 1'b1; i_hi_we = 1'b1; i_op = OP_DIVU;
    i_data_rs = 32'h1234_5678; i_data_rt = 32'd5;
    @(negedge clk);
    i_start = 1'b0; i_hi_we = 1'b0;
    wait_done(10, o_hi, o_lo, lat);
    chk("ignored start latency", 64'(lat), 64'd33);
    chk("ignored start result", {o_hi, o_lo}, {32'd0, 32'd3_000_000});
    @(negedge clk);
    chk("no queued start", {63'd0, o_busy}, 64'd0);

    // MTHI, then MTHI+MTLO together
    i_hi_we = 1'b1; i_data_rs = 32'h1234_5678;
    @(negedge clk);
    i_hi_we = 1'b0;
    chk("mthi", {o_hi, o_lo}, {32'h1234_5678, 32'd3_000_000});
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_data_rs = 32'hCAFE_F00D;
    @(negedge clk);
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    chk("mthi+mtlo", {o_hi, o_lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Start together with writes: start taken, writes dropped
    i_hi_we = 1'b1; i_lo_we = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7);
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    chk("start beats writes", {o_hi, o_lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    bad_busy = 1'b0; bad_hold = 1'b0;
    wait_done(0, 32'hCAFE_F00D, 32'hCAFE_F00D, lat);
    chk("start beats writes result", {o_hi, o_lo}, {32'd2, 32'd14});
    chk("start beats writes hold", {62'd0, bad_busy, bad_hold}, 64'd0);

    // Reset mid-divide aborts without a done pulse
    @(negedge clk);
    issue(OP_DIVU, 32'd123456, 32'd7);
    repeat (14) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("abort state", {30'd0, o_busy, o_done, o_hi, o_lo}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_done || o_busy) saw_done = 1'b1;
    end
    chk("no done after abort", {63'd0, saw_done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
